// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use interlock, memory-wait freeze
// with timeout, taken-branch flush, plus a saturating stall counter and sticky error flag.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs_i,
    input  logic [4:0]       ID_rt_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             PCWrite_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             EXMEM_write_o,
    output logic             MEMWB_bubble_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [7:0]       wait_cnt_reg, wait_cnt_next;
    logic             mem_err_reg, mem_err_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

    logic timeout;
    logic freeze;
    logic load_use;

    always_comb begin
        timeout  = (state_reg == MEM_WAIT) && (wait_cnt_reg == WAIT_LAST);
        freeze   = ((state_reg == RUN) && mem_req_i && !mem_ack_i) ||
                   ((state_reg == MEM_WAIT) && !mem_ack_i && !timeout);
        load_use = EX_MemRead_i && (EX_rt_i != 5'd0) &&
                   ((EX_rt_i == ID_rs_i) || (EX_rt_i == ID_rt_i));
    end

    // Pipeline-register controls; reset overrides everything, then freeze > load_use > branch.
    always_comb begin
        PCWrite_o      = 1'b1;
        IFID_write_o   = 1'b1;
        IFID_flush_o   = 1'b0;
        IDEX_bubble_o  = 1'b0;
        EXMEM_write_o  = 1'b1;
        MEMWB_bubble_o = 1'b0;
        if (rst_i) begin
            PCWrite_o      = 1'b0;
            IFID_write_o   = 1'b0;
            IFID_flush_o   = 1'b1;
            IDEX_bubble_o  = 1'b1;
            EXMEM_write_o  = 1'b0;
            MEMWB_bubble_o = 1'b1;
        end else if (freeze) begin
            PCWrite_o      = 1'b0;
            IFID_write_o   = 1'b0;
            EXMEM_write_o  = 1'b0;
            MEMWB_bubble_o = 1'b1;
        end else if (load_use) begin
            PCWrite_o      = 1'b0;
            IFID_write_o   = 1'b0;
            IDEX_bubble_o  = 1'b1;
        end else if (branch_taken_i) begin
            IFID_flush_o   = 1'b1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        mem_err_next   = mem_err_reg;
        stall_cnt_next = stall_cnt_reg;
        case (state_reg)
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 8'd0;
                end
            end
            MEM_WAIT: begin
                // A late ack wins over a simultaneous timeout, so no error is flagged then.
                if (mem_ack_i) begin
                    state_next = RUN;
                end else if (timeout) begin
                    state_next   = RUN;
                    mem_err_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            default: state_next = RUN;
        endcase
        if (!PCWrite_o && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= 8'd0;
            mem_err_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            mem_err_reg   <= mem_err_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign mem_err_o   = mem_err_reg;
    assign stall_cnt_o = stall_cnt_reg;

endmodule
